// File: rtl/dmac_lookup_pkg.sv
// rtl/dmac_lookup_pkg.sv - standard descriptor layout, broadcast constant and lookup FSM states
package dmac_lookup_pkg;

   localparam int DESC_W     = 71;
   localparam int DMAC_HI    = 70;
   localparam int DMAC_LO    = 23;
   localparam int INPORT_HI  = 22;
   localparam int INPORT_LO  = 19;
   localparam int LKEN_BIT   = 18;
   localparam int OUTPORT_HI = 17;
   localparam int OUTPORT_LO = 9;
   localparam int BUFID_HI   = 8;
   localparam int BUFID_LO   = 0;

   localparam logic [47:0] BCAST_DMAC = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_OUTPUT = 2'd2
   } lookup_state_e;

endpackage

// File: rtl/dmac_desc_fifo.sv
// rtl/dmac_desc_fifo.sv - first-word-fall-through descriptor FIFO with full/empty/count status
module dmac_desc_fifo #(
   parameter  int WIDTH = 71,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] iv_wdata,
   input  logic             i_rd,
   output logic [WIDTH-1:0] ov_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    ov_count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             wr_ok;
   logic             rd_ok;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_empty  = (ov_count == '0);
   assign o_full   = (ov_count == CW'(DEPTH));
   assign rd_ok    = i_rd && !o_empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign wr_ok    = i_wr && (!o_full || rd_ok);
   assign ov_rdata = mem[rptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         ov_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            mem[wptr] <= iv_wdata;
            wptr      <= ptr_inc(wptr);
         end
         if (rd_ok) begin
            rptr <= ptr_inc(rptr);
         end
         case ({wr_ok, rd_ok})
            2'b10:   ov_count <= ov_count + 1'b1;
            2'b01:   ov_count <= ov_count - 1'b1;
            default: ov_count <= ov_count;
         endcase
      end
   end

endmodule

// File: rtl/dmac_lookup_table.sv
// rtl/dmac_lookup_table.sv - sequential DMAC table search resolving the outport of standard descriptors
module dmac_lookup_table
   import dmac_lookup_pkg::*;
#(
   parameter  int DEPTH      = 16,
   parameter  int PORT_NUM   = 9,
   parameter  int FIFO_DEPTH = 4,
   localparam int IDX_W      = $clog2(DEPTH),
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [DESC_W-1:0]   iv_standard_descriptor,
   input  logic                i_standard_descriptor_wr,
   input  logic                i_table_wr,
   input  logic [IDX_W-1:0]    iv_table_addr,
   input  logic [47:0]         iv_table_dmac,
   input  logic [PORT_NUM-1:0] iv_table_outport,
   input  logic                i_table_valid,
   output logic [DESC_W-1:0]   ov_standard_descriptor,
   output logic                o_standard_descriptor_wr,
   output logic [15:0]         ov_drop_cnt
);

   logic                tbl_valid   [DEPTH];
   logic [47:0]         tbl_dmac    [DEPTH];
   logic [PORT_NUM-1:0] tbl_outport [DEPTH];

   lookup_state_e       state;
   lookup_state_e       state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_nxt;
   logic [DESC_W-1:0]   work;
   logic [DESC_W-1:0]   work_nxt;
   logic                out_load;

   logic [DESC_W-1:0]   fifo_rdata;
   logic                fifo_empty;
   logic                fifo_full_unused;
   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_pop;
   logic                drop_evt;

   logic [PORT_NUM-1:0] flood_mask;
   logic                entry_hit;
   logic                first_cycle;

   dmac_desc_fifo #(
      .WIDTH (DESC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_desc_fifo (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wr     (i_standard_descriptor_wr),
      .iv_wdata (iv_standard_descriptor),
      .i_rd     (fifo_pop),
      .ov_rdata (fifo_rdata),
      .o_full   (fifo_full_unused),
      .o_empty  (fifo_empty),
      .ov_count (fifo_count)
   );

   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
   assign drop_evt = i_standard_descriptor_wr && !fifo_pop &&
                     !(fifo_count < CNT_W'(FIFO_DEPTH));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_valid[i]   <= 1'b0;
            tbl_dmac[i]    <= '0;
            tbl_outport[i] <= '0;
         end
      end else if (i_table_wr) begin
         tbl_valid[iv_table_addr]   <= i_table_valid;
         tbl_dmac[iv_table_addr]    <= iv_table_dmac;
         tbl_outport[iv_table_addr] <= iv_table_outport;
      end
   end

   // Flood everywhere except back out of the ingress port; an out-of-range inport floods all.
   always_comb begin
      flood_mask = '1;
      for (int p = 0; p < PORT_NUM; p++) begin
         if (int'(work[INPORT_HI:INPORT_LO]) == p) begin
            flood_mask[p] = 1'b0;
         end
      end
   end

   assign entry_hit   = tbl_valid[idx] && (tbl_dmac[idx] == work[DMAC_HI:DMAC_LO]);
   assign first_cycle = (idx == '0);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      work_nxt  = work;
      out_load  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               work_nxt  = fifo_rdata;
               idx_nxt   = '0;
               state_nxt = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (first_cycle && !work[LKEN_BIT]) begin
               out_load  = 1'b1;
               state_nxt = ST_OUTPUT;
            end else if (first_cycle && (work[DMAC_HI:DMAC_LO] == BCAST_DMAC)) begin
               work_nxt[OUTPORT_HI:OUTPORT_LO] = flood_mask;
               out_load  = 1'b1;
               state_nxt = ST_OUTPUT;
            end else if (entry_hit) begin
               work_nxt[OUTPORT_HI:OUTPORT_LO] = tbl_outport[idx];
               out_load  = 1'b1;
               state_nxt = ST_OUTPUT;
            end else if (idx == IDX_W'(DEPTH - 1)) begin
               work_nxt[OUTPORT_HI:OUTPORT_LO] = flood_mask;
               out_load  = 1'b1;
               state_nxt = ST_OUTPUT;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         ST_OUTPUT: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         work  <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         work  <= work_nxt;
      end
   end

   // The output register is loaded on entry to OUTPUT so the pulse lines up with that state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ov_standard_descriptor   <= '0;
         o_standard_descriptor_wr <= 1'b0;
      end else begin
         ov_standard_descriptor   <= out_load ? work_nxt : '0;
         o_standard_descriptor_wr <= out_load;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ov_drop_cnt <= '0;
      end else if (drop_evt && (ov_drop_cnt != 16'hFFFF)) begin
         ov_drop_cnt <= ov_drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_dmac_lookup_table.sv
// tb/tb_dmac_lookup_table.sv - scoreboard bench for the DMAC lookup stage
module tb_dmac_lookup_table;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [70:0] desc_in = '0;
   logic        desc_wr = 1'b0;
   logic        tbl_wr = 1'b0;
   logic [3:0]  tbl_addr = '0;
   logic [47:0] tbl_dmac = '0;
   logic [8:0]  tbl_outport = '0;
   logic        tbl_valid = 1'b0;
   logic [70:0] out_desc;
   logic        out_wr;
   logic [15:0] drop_cnt;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [70:0] exp_desc_q [$];
   int          exp_cyc_q [$];

   localparam logic [47:0] DMAC_A = 48'h0011_2233_4455;
   localparam logic [47:0] DMAC_P = 48'h0A0B_0C0D_0E0F;
   localparam logic [47:0] DMAC_U = 48'hDEAD_BEEF_0001;
   localparam logic [47:0] DMAC_W = 48'h5566_7788_99AA;

   always #4 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmac_lookup_table dut (
      .i_clk                    (clk),
      .i_rst_n                  (rst_n),
      .iv_standard_descriptor   (desc_in),
      .i_standard_descriptor_wr (desc_wr),
      .i_table_wr               (tbl_wr),
      .iv_table_addr            (tbl_addr),
      .iv_table_dmac            (tbl_dmac),
      .iv_table_outport         (tbl_outport),
      .i_table_valid            (tbl_valid),
      .ov_standard_descriptor   (out_desc),
      .o_standard_descriptor_wr (out_wr),
      .ov_drop_cnt              (drop_cnt)
   );

   task automatic check_val(input string tag, input logic [70:0] act, input logic [70:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic logic [70:0] mk_desc(input logic [47:0] dmac, input logic [3:0] inport,
                                           input logic lken, input logic [8:0] outport,
                                           input logic [8:0] bufid);
      return {dmac, inport, lken, outport, bufid};
   endfunction

   function automatic logic [8:0] flood(input logic [3:0] inport);
      logic [8:0] m;
      m = 9'h1FF;
      for (int p = 0; p < 9; p++) begin
         if (int'(inport) == p) m[p] = 1'b0;
      end
      return m;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_wr) begin
         if (exp_desc_q.size() == 0) begin
            check_val("unexpected_wr", 71'(out_desc), 71'(0));
         end else begin
            check_val("desc", out_desc, exp_desc_q.pop_front());
            check_val("wr_cycle", 71'(cyc), 71'(exp_cyc_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [70:0] d, input logic [70:0] exp, input int exp_cycle,
                       input bit expect_out);
      desc_in = d;
      desc_wr = 1'b1;
      if (expect_out) begin
         exp_desc_q.push_back(exp);
         exp_cyc_q.push_back(exp_cycle);
      end
      tick(1);
      desc_wr = 1'b0;
   endtask

   task automatic tbl_write(input logic [3:0] a, input logic [47:0] dm, input logic [8:0] op,
                            input logic v);
      tbl_wr      = 1'b1;
      tbl_addr    = a;
      tbl_dmac    = dm;
      tbl_outport = op;
      tbl_valid   = v;
      tick(1);
      tbl_wr      = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_desc_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      if (exp_desc_q.size() != 0) begin
         check_val("drain_timeout", 71'(exp_desc_q.size()), 71'(0));
         exp_desc_q.delete();
         exp_cyc_q.delete();
      end
      tick(2);
   endtask

   initial begin
      int t0;
      tick(3);
      check_val("rst_desc", out_desc, 71'(0));
      check_val("rst_wr", 71'(out_wr), 71'(0));
      check_val("rst_drop", 71'(drop_cnt), 71'(0));
      rst_n = 1'b1;
      tick(2);

      tbl_write(4'd5, DMAC_A, 9'h004, 1'b1);
      send(mk_desc(DMAC_A, 4'd1, 1'b1, 9'h000, 9'h1A5),
           mk_desc(DMAC_A, 4'd1, 1'b1, 9'h004, 9'h1A5), cyc + 8, 1'b1);
      drain(40);

      send(mk_desc(DMAC_U, 4'd2, 1'b1, 9'h000, 9'h011),
           mk_desc(DMAC_U, 4'd2, 1'b1, flood(4'd2), 9'h011), cyc + 18, 1'b1);
      drain(40);
      send(mk_desc(48'hFFFF_FFFF_FFFF, 4'd2, 1'b1, 9'h000, 9'h022),
           mk_desc(48'hFFFF_FFFF_FFFF, 4'd2, 1'b1, 9'h1FB, 9'h022), cyc + 3, 1'b1);
      drain(40);
      send(mk_desc(48'hFFFF_FFFF_FFFF, 4'd12, 1'b1, 9'h000, 9'h033),
           mk_desc(48'hFFFF_FFFF_FFFF, 4'd12, 1'b1, 9'h1FF, 9'h033), cyc + 3, 1'b1);
      drain(40);

      send(mk_desc(DMAC_A, 4'd3, 1'b0, 9'h080, 9'h044),
           mk_desc(DMAC_A, 4'd3, 1'b0, 9'h080, 9'h044), cyc + 3, 1'b1);
      drain(40);

      tbl_write(4'd3, DMAC_P, 9'h011, 1'b1);
      tbl_write(4'd9, DMAC_P, 9'h102, 1'b1);
      send(mk_desc(DMAC_P, 4'd0, 1'b1, 9'h000, 9'h055),
           mk_desc(DMAC_P, 4'd0, 1'b1, 9'h011, 9'h055), cyc + 6, 1'b1);
      drain(40);
      tbl_write(4'd3, DMAC_P, 9'h011, 1'b0);
      send(mk_desc(DMAC_P, 4'd0, 1'b1, 9'h000, 9'h066),
           mk_desc(DMAC_P, 4'd0, 1'b1, 9'h102, 9'h066), cyc + 12, 1'b1);
      drain(40);

      send(mk_desc(DMAC_W, 4'd4, 1'b1, 9'h000, 9'h077),
           mk_desc(DMAC_W, 4'd4, 1'b1, 9'h0AA, 9'h077), cyc + 18, 1'b1);
      tbl_write(4'd15, DMAC_W, 9'h0AA, 1'b1);
      drain(40);

      // Lead miss keeps the FSM searching while a six-deep burst hits the FIFO.
      check_val("drop_before", 71'(drop_cnt), 71'(0));
      t0 = cyc;
      send(mk_desc(48'hCAFE_0000_0000, 4'd2, 1'b1, 9'h000, 9'h100),
           mk_desc(48'hCAFE_0000_0000, 4'd2, 1'b1, 9'h1FB, 9'h100), t0 + 18, 1'b1);
      tick(1);
      for (int i = 0; i < 6; i++) begin
         send(mk_desc(48'hCAFE_0000_0001 + 48'(i), 4'd2, 1'b1, 9'h000, 9'h101 + 9'(i)),
              mk_desc(48'hCAFE_0000_0001 + 48'(i), 4'd2, 1'b1, 9'h1FB, 9'h101 + 9'(i)),
              t0 + 18 + 18 * (i + 1), (i < 4));
      end
      drain(200);
      check_val("drop_cnt", 71'(drop_cnt), 71'(2));

      send(mk_desc(DMAC_A, 4'd1, 1'b1, 9'h000, 9'h1C0), '0, 0, 1'b0);
      tick(3);
      rst_n = 1'b0;
      tick(2);
      check_val("midrst_desc", out_desc, 71'(0));
      check_val("midrst_wr", 71'(out_wr), 71'(0));
      check_val("midrst_drop", 71'(drop_cnt), 71'(0));
      rst_n = 1'b1;
      tick(20);
      send(mk_desc(DMAC_A, 4'd1, 1'b1, 9'h000, 9'h1C1),
           mk_desc(DMAC_A, 4'd1, 1'b1, flood(4'd1), 9'h1C1), cyc + 18, 1'b1);
      drain(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
